// File: rtl/mas_alu_divider.sv
// mas_alu_divider: sequential unsigned restoring divider, one quotient bit per clock.
// Width comes from the global MAS_BLEN define. A zero divisor bypasses the iteration
// and reports res = all ones, rem = dividend, div_zero = 1.

`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

module mas_alu_divider (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [`MAS_BLEN-1:0] op1,
    input  logic [`MAS_BLEN-1:0] op2,
    output logic                 busy,
    output logic                 ready,
    output logic [`MAS_BLEN-1:0] res,
    output logic [`MAS_BLEN-1:0] rem,
    output logic                 div_zero
);

    localparam int unsigned N  = `MAS_BLEN;
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Architectural state
    state_t          r_state;
    logic [N-1:0]    r_dividend;
    logic [N-1:0]    r_divisor;
    logic [N-1:0]    r_prem;
    logic [N-2:0]    r_quot;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_ready;
    logic [N-1:0]    r_res;
    logic [N-1:0]    r_rem;
    logic            r_div_zero;

    // Next-state values
    state_t          w_state_nxt;
    logic [N-1:0]    w_dividend_nxt;
    logic [N-1:0]    w_divisor_nxt;
    logic [N-1:0]    w_prem_nxt;
    logic [N-2:0]    w_quot_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_busy_nxt;
    logic            w_ready_nxt;
    logic [N-1:0]    w_res_nxt;
    logic [N-1:0]    w_rem_nxt;
    logic            w_div_zero_nxt;

    // One restoring step; N+1 bits keep the shifted-out MSB for large divisors
    logic [N:0]      w_trial;
    logic            w_ge;
    logic [N-1:0]    w_prem_step;
    logic [N-1:0]    w_quot_step;

    assign busy     = r_busy;
    assign ready    = r_ready;
    assign res      = r_res;
    assign rem      = r_rem;
    assign div_zero = r_div_zero;

    // Shift next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        w_trial     = {r_prem, r_dividend[N-1]};
        w_ge        = (w_trial >= {1'b0, r_divisor});
        w_prem_step = w_ge ? N'(w_trial - {1'b0, r_divisor}) : w_trial[N-1:0];
        w_quot_step = {r_quot, w_ge};
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_prem_nxt     = r_prem;
        w_quot_nxt     = r_quot;
        w_cnt_nxt      = r_cnt;
        w_ready_nxt    = 1'b0;
        w_res_nxt      = r_res;
        w_rem_nxt      = r_rem;
        w_div_zero_nxt = r_div_zero;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dividend_nxt = op1;
                    w_divisor_nxt  = op2;
                    w_prem_nxt     = '0;
                    w_quot_nxt     = '0;
                    w_cnt_nxt      = '0;
                    if (op2 == '0) begin
                        w_state_nxt    = S_DONE;
                        w_ready_nxt    = 1'b1;
                        w_res_nxt      = '1;
                        w_rem_nxt      = op1;
                        w_div_zero_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_dividend_nxt = {r_dividend[N-2:0], 1'b0};
                w_prem_nxt     = w_prem_step;
                w_quot_nxt     = w_quot_step[N-2:0];
                w_cnt_nxt      = r_cnt + CW'(1);
                if (r_cnt == CW'(N - 1)) begin
                    w_state_nxt    = S_DONE;
                    w_ready_nxt    = 1'b1;
                    w_res_nxt      = w_quot_step;
                    w_rem_nxt      = w_prem_step;
                    w_div_zero_nxt = 1'b0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_prem     <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_res      <= '0;
            r_rem      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_prem     <= w_prem_nxt;
            r_quot     <= w_quot_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_ready    <= w_ready_nxt;
            r_res      <= w_res_nxt;
            r_rem      <= w_rem_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

endmodule

// File: tb/tb_mas_alu_divider.sv
// Testbench for mas_alu_divider: directed steps plus a back-to-back random run,
// expected results queued at start and compared when ready pulses.

`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

module tb_mas_alu_divider;

    localparam int N = `MAS_BLEN;
    localparam int P = N + 2;

    typedef struct packed {
        logic [N-1:0] res;
        logic [N-1:0] rem;
        logic         dz;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic         busy;
    logic         ready;
    logic [N-1:0] res;
    logic [N-1:0] rem;
    logic         div_zero;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    mas_alu_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op1      (op1),
        .op2      (op2),
        .busy     (busy),
        .ready    (ready),
        .res      (res),
        .rem      (rem),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.res = '1;
            e.rem = a;
            e.dz  = 1'b1;
        end else begin
            e.res = a / b;
            e.rem = a % b;
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, ":busy"},  N'(busy),     '0);
        check({tag, ":ready"}, N'(ready),    '0);
        check({tag, ":res"},   res,          '0);
        check({tag, ":rem"},   rem,          '0);
        check({tag, ":dz"},    N'(div_zero), '0);
    endtask

    task automatic pop_and_compare(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s:sb_empty observed=0 expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ":res"}, res,          e.res);
            check({tag, ":rem"}, rem,          e.rem);
            check({tag, ":dz"},  N'(div_zero), N'(e.dz));
        end
    endtask

    // Called at a negedge with the DUT idle; start is accepted on the next posedge.
    // ready is expected high across the (N+1)th rising edge after accept (1st for /0).
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] er, input logic [N-1:0] erm, input logic edz,
                          input int repulse);
        int   j;
        int   nbusy;
        int   exp_lat;
        exp_t e;
        e.res = er;
        e.rem = erm;
        e.dz  = edz;
        start = 1'b1;
        op1   = a;
        op2   = b;
        sb.push_back(e);
        exp_lat = (b == '0) ? 0 : N;
        @(negedge clk);
        start = 1'b0;
        op1   = N'($urandom);
        op2   = N'($urandom);
        j     = 0;
        nbusy = 0;
        while (ready !== 1'b1 && j <= N + 4) begin
            if (busy === 1'b1) nbusy++;
            if (j == repulse) begin
                start = 1'b1;
                op1   = N'(50);
                op2   = N'(5);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        if (busy === 1'b1) nbusy++;
        check({tag, ":latency"},    N'(j),     N'(exp_lat));
        check({tag, ":busy_count"}, N'(nbusy), N'(exp_lat + 1));
        pop_and_compare(tag);
        @(negedge clk);
        check({tag, ":ready_drop"}, N'(ready), '0);
        check({tag, ":busy_drop"},  N'(busy),  '0);
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           nres;

        rst_n = 1'b0;
        start = 1'b0;
        op1   = '0;
        op2   = '0;
        #1;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);

        run_op("div_100_7", N'(100), N'(7), N'(14), N'(2), 1'b0, -1);
        run_op("all1_by_1", N'(32'hFFFF_FFFF), N'(1), N'(32'hFFFF_FFFF), N'(0), 1'b0, -1);
        run_op("all1_by_msb", N'(32'hFFFF_FFFF), N'(32'h8000_0000), N'(1), N'(32'h7FFF_FFFF), 1'b0, -1);

        // Abort 10 cycles into CALC
        start = 1'b1;
        op1   = N'(32'h0000_0ABC);
        op2   = N'(7);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("async_abort");
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("abort_held");
        rst_n = 1'b1;
        run_op("after_reset_20_6", N'(20), N'(6), N'(3), N'(2), 1'b0, -1);

        run_op("div_by_zero", N'(32'h1234), N'(0), N'(32'hFFFF_FFFF), N'(32'h1234), 1'b1, -1);
        run_op("div_9_3", N'(9), N'(3), N'(3), N'(0), 1'b0, -1);
        run_op("restart_ignored", N'(5), N'(9), N'(0), N'(5), 1'b0, 10);
        run_op("small_dividend", N'(3), N'(10), N'(0), N'(3), 1'b0, -1);
        run_op("zero_dividend", N'(0), N'(5), N'(0), N'(0), 1'b0, -1);
        run_op("max_by_max", N'(32'hFFFF_FFFF), N'(32'hFFFF_FFFF), N'(1), N'(0), 1'b0, -1);

        // Back-to-back with start held high: accepts every P edges
        nres = 0;
        for (int k = 0; k < 6 * P; k++) begin
            a = N'($urandom);
            b = N'($urandom) >> $urandom_range(0, N - 1);
            if (b == '0) b = N'(1);
            start = 1'b1;
            op1   = a;
            op2   = b;
            if (k % P == 0) sb.push_back(model(a, b));
            @(negedge clk);
            if ((k % P) == N || ready === 1'b1) begin
                check("b2b:ready", N'(ready), N'((k % P) == N));
                if (ready === 1'b1) begin
                    pop_and_compare("b2b");
                    nres++;
                end
            end
        end
        start = 1'b0;
        check("b2b:results", N'(nres), N'(6));
        check("b2b:sb_left", N'(sb.size()), '0);
        repeat (3) @(negedge clk);
        check("final_idle_busy", N'(busy), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
